// File: rtl/cache_bus_arbiter_pkg.sv
// cache_bus_pkg: shared types for the cache bus arbiter (FSM states, owner ids, line type, word slicing)
package cache_bus_pkg;
  localparam int LINE_WORDS = 8;
  typedef enum logic [2:0] {IDLE, ADDR, WBEAT, WRESP, RBEAT, DONE} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;
  typedef logic [255:0] line_t;
  function automatic logic [31:0] line_word(line_t l, logic [2:0] i);
    return l[32*i +: 32];
  endfunction
endpackage

// File: rtl/cache_bus_arbiter_line_buffer.sv
// line_buffer_8x32: 8x32 line register, whole-line load, indexed beat write, indexed beat read
// clk/resetn: clock, async active-low reset; load_i/line_i: load a whole line;
// wr_i/idx_i/wdata_i: write one word; rdata_o: word at idx_i; line_o: whole line
module line_buffer_8x32
  import cache_bus_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_i,
  input  line_t       line_i,
  input  logic        wr_i,
  input  logic [2:0]  idx_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output line_t       line_o
);
  line_t line_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) line_q <= '0;
    else if (load_i) line_q <= line_i;
    else if (wr_i) line_q[32*idx_i +: 32] <= wdata_i;
  assign line_o  = line_q;
  assign rdata_o = line_word(line_q, idx_i);
endmodule

// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: round-robin share of one burst memory port between icache (reads) and dcache (reads, writebacks)
// Cache side: *_addr/*_rd_req/d_wr_req/d_wr_data in, *_gnt one-cycle completion pulse, *_rd_data registered line.
// Bus side: bus_req/bus_we/bus_addr/bus_ack address phase, bus_w* write beats, bus_bvalid response,
// bus_r* read beats, bus_err sticky early-rlast flag.
module cache_bus_arbiter #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_rd_req,
  input  logic              d_wr_req,
  input  logic [255:0]      d_wr_data,
  output logic              d_gnt,
  output logic [255:0]      d_rd_data,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_rd_req,
  output logic              i_gnt,
  output logic [255:0]      i_rd_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  output logic [31:0]       bus_wdata,
  output logic              bus_wvalid,
  output logic              bus_wlast,
  input  logic              bus_wready,
  input  logic              bus_bvalid,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_rvalid,
  input  logic              bus_rlast,
  output logic              bus_err
);
  import cache_bus_pkg::*;
  localparam logic [2:0] LAST = 3'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(31);
  state_e state_q, state_d;
  owner_e own_q, own_d, last_q, last_d;
  logic we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0] cnt_q, cnt_d;
  line_t d_line_q, i_line_q, buf_line, fill_d;
  logic [31:0] buf_word;
  logic d_req, pick_d, buf_load, buf_wr, fill_en;
  a_line_words: assert property (@(posedge clk) LINE_WORDS == 8);
  assign d_req   = d_rd_req | d_wr_req;
  assign pick_d  = d_req && (!i_rd_req || last_q == OWN_I);
  assign buf_wr  = state_q == RBEAT && bus_rvalid;
  assign fill_en = buf_wr && cnt_q == LAST;
  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    err_d    = err_q | (buf_wr && bus_rlast && cnt_q != LAST);
    buf_load = 1'b0;
    fill_d   = buf_line;
    fill_d[32*(LINE_WORDS-1) +: 32] = bus_rdata;
    case (state_q)
      IDLE: if (d_req || i_rd_req) begin
        own_d    = pick_d ? OWN_D : OWN_I;
        we_d     = pick_d && d_wr_req;
        addr_d   = (pick_d ? d_addr : i_addr) & ALIGN;
        buf_load = pick_d && d_wr_req;
        state_d  = ADDR;
      end
      ADDR: if (bus_ack) begin
        state_d = we_q ? WBEAT : RBEAT;
        cnt_d   = '0;
      end
      WBEAT: if (bus_wready) begin
        cnt_d   = cnt_q + 3'd1;
        state_d = cnt_q == LAST ? WRESP : WBEAT;
      end
      WRESP: state_d = bus_bvalid ? DONE : WRESP;
      RBEAT: if (bus_rvalid) begin
        cnt_d   = cnt_q + 3'd1;
        state_d = cnt_q == LAST ? DONE : RBEAT;
      end
      DONE: begin
        last_d  = own_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q  <= IDLE;
      own_q    <= OWN_I;
      last_q   <= OWN_I;
      we_q     <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      d_line_q <= '0;
      i_line_q <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      // the final beat is still on bus_rdata, so the line is assembled around it
      if (fill_en && own_q == OWN_D) d_line_q <= fill_d;
      if (fill_en && own_q == OWN_I) i_line_q <= fill_d;
    end
  line_buffer_8x32 u_buf (
    .clk     (clk),
    .resetn  (resetn),
    .load_i  (buf_load),
    .line_i  (d_wr_data),
    .wr_i    (buf_wr),
    .idx_i   (cnt_q),
    .wdata_i (bus_rdata),
    .rdata_o (buf_word),
    .line_o  (buf_line)
  );
  assign bus_req    = state_q == ADDR;
  assign bus_we     = bus_req && we_q;
  assign bus_addr   = addr_q;
  assign bus_wvalid = state_q == WBEAT;
  assign bus_wdata  = buf_word;
  assign bus_wlast  = bus_wvalid && cnt_q == LAST;
  assign d_gnt      = state_q == DONE && own_q == OWN_D;
  assign i_gnt      = state_q == DONE && own_q == OWN_I;
  assign d_rd_data  = d_line_q;
  assign i_rd_data  = i_line_q;
  assign bus_err    = err_q;
endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb_cache_bus_arbiter: randomized bus responder with a transaction-level arbitration/data model
module tb_cache_bus_arbiter;
  logic clk = 1'b0, resetn;
  logic [31:0] d_addr, i_addr, bus_addr, bus_wdata, bus_rdata;
  logic d_rd_req, d_wr_req, d_gnt, i_rd_req, i_gnt;
  logic [255:0] d_wr_data, d_rd_data, i_rd_data;
  logic bus_req, bus_we, bus_ack, bus_wvalid, bus_wlast, bus_wready, bus_bvalid, bus_rvalid, bus_rlast, bus_err;
  always #5 clk = ~clk;
  cache_bus_arbiter dut (
    .clk(clk), .resetn(resetn),
    .d_addr(d_addr), .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_wr_data(d_wr_data),
    .d_gnt(d_gnt), .d_rd_data(d_rd_data),
    .i_addr(i_addr), .i_rd_req(i_rd_req), .i_gnt(i_gnt), .i_rd_data(i_rd_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_ack(bus_ack),
    .bus_wdata(bus_wdata), .bus_wvalid(bus_wvalid), .bus_wlast(bus_wlast), .bus_wready(bus_wready),
    .bus_bvalid(bus_bvalid), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .bus_rlast(bus_rlast),
    .bus_err(bus_err)
  );
  int checks = 0, failures = 0;
  int gap, early, cyc, gnt_cyc;
  bit alt, hold, last_d, got_d;
  logic [255:0] exp_i, exp_d;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    chk("no_gnt", {d_gnt, i_gnt}, 0);
    @(negedge clk);
    cyc++;
  endtask
  function automatic int rgap();
    return gap == 0 ? 0 : int'($urandom_range(0, gap));
  endfunction
  task automatic serve();
    bit own_d, we, tog;
    logic [31:0] a;
    logic [255:0] wl, rl;
    int n;
    own_d = (d_rd_req | d_wr_req) && (!i_rd_req || !last_d);
    we    = own_d && d_wr_req;
    a     = own_d ? d_addr : i_addr;
    a[4:0] = 5'd0;
    wl    = d_wr_data;
    rl    = '0;
    n = 0;
    while (!bus_req && n < 20) begin step(); n++; end
    chk("bus_req", bus_req, 1);
    if (!bus_req) return;
    chk("bus_we", bus_we, we);
    chk("bus_addr", bus_addr, a);
    repeat (rgap()) step();
    bus_ack = 1; step(); bus_ack = 0;
    if (we) begin
      n = 0; tog = 0;
      for (int k = 0; k < 8 && n < 100;) begin
        bus_wready = alt ? tog : (gap == 0 ? 1'b1 : 1'($urandom_range(0, 1)));
        tog = !tog;
        chk("wvalid", bus_wvalid, 1);
        chk("wdata", bus_wdata, wl[32*k +: 32]);
        chk("wlast", bus_wlast, k == 7);
        step(); n++;
        if (bus_wready) k++;
      end
      bus_wready = 0;
      repeat (rgap()) step();
      bus_bvalid = 1; step(); bus_bvalid = 0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        repeat (rgap()) step();
        bus_rvalid = 1;
        bus_rdata  = $urandom;
        bus_rlast  = early >= 0 ? k == early : k == 7;
        rl[32*k +: 32] = bus_rdata;
        step();
        bus_rvalid = 0; bus_rlast = 0;
      end
      if (own_d) exp_d = rl; else exp_i = rl;
    end
    gnt_cyc = cyc;
    got_d = d_gnt;
    chk("d_gnt", d_gnt, own_d);
    chk("i_gnt", i_gnt, !own_d);
    chk("d_rd_data", d_rd_data, exp_d);
    chk("i_rd_data", i_rd_data, exp_i);
    last_d = own_d;
    if (!hold) begin
      if (!own_d) i_rd_req = 0; else if (we) d_wr_req = 0; else d_rd_req = 0;
    end
    @(negedge clk); cyc++;
    chk("gnt_pulse", {d_gnt, i_gnt}, 0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_bus"}, {bus_req, bus_we, bus_addr, bus_wvalid, bus_wlast, bus_err, d_gnt, i_gnt}, 0);
    chk({tag, "_d_rd_data"}, d_rd_data, 0);
    chk({tag, "_i_rd_data"}, i_rd_data, 0);
  endtask
  task automatic do_reset();
    resetn = 0;
    {d_rd_req, d_wr_req, i_rd_req, bus_ack, bus_wready, bus_bvalid, bus_rvalid, bus_rlast} = '0;
    d_addr = 0; i_addr = 0; d_wr_data = 0; bus_rdata = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    resetn = 1;
    last_d = 0; exp_i = 0; exp_d = 0;
  endtask
  task automatic rand_line(output logic [255:0] l);
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    gap = 0; early = -1; alt = 0; hold = 0; cyc = 0;
    do_reset();
    // icache-only read, all handshakes immediate
    i_addr = 32'h1FC0_0024; i_rd_req = 1; cyc = 0;
    serve();
    chk("i_rd_latency", gnt_cyc, 10);
    // dcache writeback latency, handshakes immediate
    for (int k = 0; k < 8; k++) d_wr_data[32*k +: 32] = 32'hA0 + k;
    d_addr = 32'h8000_1234; d_wr_req = 1; cyc = 0;
    serve();
    chk("d_wr_latency", gnt_cyc, 11);
    // writeback then refill, wready toggling
    d_addr = 32'h4000_00FF; d_wr_req = 1; d_rd_req = 1; alt = 1; gap = 1;
    serve();
    serve();
    alt = 0;
    // simultaneous from reset: D first since I was last served
    do_reset();
    gap = 2; d_addr = $urandom; i_addr = $urandom; d_rd_req = 1; i_rd_req = 1;
    serve();
    chk("first_owner_d", got_d, 1);
    serve();
    chk("second_owner_i", got_d, 0);
    // continuous requests alternate D, I, D, I, D, I
    hold = 1; d_rd_req = 1; i_rd_req = 1;
    for (int k = 0; k < 6; k++) begin
      serve();
      chk("alternate", got_d, k % 2 == 0);
    end
    d_rd_req = 0; i_rd_req = 0; hold = 0;
    // early rlast
    chk("err_before", bus_err, 0);
    early = 5; i_rd_req = 1; i_addr = $urandom;
    serve();
    chk("err_set", bus_err, 1);
    early = -1; i_rd_req = 1;
    serve();
    chk("err_sticky", bus_err, 1);
    // reset during beat 4 of a read
    gap = 0; i_rd_req = 1; i_addr = $urandom;
    for (int n = 0; n < 20 && !bus_req; n++) step();
    bus_ack = 1; step(); bus_ack = 0;
    for (int k = 0; k < 4; k++) begin
      bus_rvalid = 1; bus_rdata = $urandom; step();
    end
    bus_rdata = $urandom;
    #1 resetn = 0;
    #1 chk_zero("async_reset");
    bus_rvalid = 0; i_rd_req = 0;
    repeat (2) step();
    resetn = 1;
    last_d = 0; exp_i = 0; exp_d = 0;
    step();
    chk_zero("after_reset");
    i_rd_req = 1;
    serve();
    // randomized traffic
    gap = 3;
    for (int t = 0; t < 24; t++) begin
      if (!(d_rd_req | d_wr_req | i_rd_req)) begin
        {d_wr_req, d_rd_req, i_rd_req} = 3'($urandom_range(1, 7));
        d_addr = $urandom; i_addr = $urandom;
        rand_line(d_wr_data);
      end
      serve();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
Shares one burst-capable memory port between the instruction cache (line reads only) and the data cache (line reads and dirty-line writebacks). It presents each cache with a whole-line request/grant interface: 8 x 32-bit words, 32-byte aligned. On the downstream side it drives a beat-serial burst port toward the AXI bridge. It sits between both caches and the AXI interface module. It serialises transactions, packs and unpacks lines, and produces the single-cycle grant pulse the caches wait on.

Parameters:
LINE_WORDS, 8, words per cache line (beat count per burst); fixed at 8, checked by assertion
ADDR_W, 32, address width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
d_addr  in  32  dcache line address, bits [4:0] ignored (forced to 0 on bus)
d_rd_req  in  1  dcache line-fill request, level, held until d_gnt
d_wr_req  in  1  dcache writeback request, level, held until d_gnt
d_wr_data  in  256  writeback line, word i at [32i+31:32i]
d_gnt  out  1  one-cycle completion pulse to dcache
d_rd_data  out  256  filled line, registered
i_addr  in  32  icache line address
i_rd_req  in  1  icache line-fill request, level, held until i_gnt
i_gnt  out  1  one-cycle completion pulse to icache
i_rd_data  out  256  filled line, registered
bus_req  out  1  burst address valid
bus_we  out  1  1 = write burst, 0 = read burst
bus_addr  out  32  burst base address, [4:0]=0
bus_ack  in  1  address accepted
bus_wdata  out  32  write beat data
bus_wvalid  out  1  write beat valid
bus_wlast  out  1  final write beat
bus_wready  in  1  write beat accepted
bus_bvalid  in  1  write response
bus_rdata  in  32  read beat data
bus_rvalid  in  1  read beat valid (no backpressure; always accepted)
bus_rlast  in  1  final read beat
bus_err  out  1  sticky: rlast arrived on a beat other than beat 7

Behaviour:
- Reset (async, resetn=0): state IDLE, all outputs 0, d_rd_data, i_rd_data and line buffer cleared, beat counter 0, last_served = ICACHE.
- States: IDLE, ADDR, WBEAT, WRESP, RBEAT, DONE.
- IDLE samples requests. Candidate set is {D if d_rd_req|d_wr_req, I if i_rd_req}.
- If both caches request, the one not equal to last_served wins (round-robin).
- If d_wr_req and d_rd_req are both high, the write is served first.
- On selection, latch the owner, op, address ({addr[31:5],5'b0}) and, for writes, d_wr_data into the line buffer. Go to ADDR.
- ADDR: bus_req=1, bus_we and bus_addr from the latch. On bus_ack, write goes to WBEAT and read goes to RBEAT; beat counter := 0.
- WBEAT: bus_wvalid=1, bus_wdata = buffer[cnt], bus_wlast = (cnt==7). On bus_wready the counter increments; on bus_wready with cnt==7, go to WRESP.
- WRESP: wait for bus_bvalid, then go to DONE.
- RBEAT: on bus_rvalid, buffer[cnt] := bus_rdata and the counter increments. On the beat with cnt==7, go to DONE.
- If bus_rlast is seen with cnt!=7, set bus_err; beat counting still decides completion.
- DONE (exactly 1 cycle): pulse the owner's gnt. For a read, the owner's rd_data register is loaded from the buffer on entry to DONE. It is valid in the DONE cycle and held until that owner's next read completes. last_served := owner. Next state IDLE.
- Requests are ignored outside IDLE. The requester must drop or change its request on the edge where it sees gnt. IDLE re-samples on the next cycle, so a dcache writeback followed by its refill re-arbitrates normally (icache may intervene).
- Minimum latency with bus_ack, wready, rvalid and bvalid all tied high:
  - read: req at cycle 0, gnt at cycle 10 (IDLE, ADDR, 8 beats, DONE)
  - write: gnt at cycle 11
- Request dropped mid-transaction: the transaction completes anyway; gnt is still pulsed.
- resetn asserted mid-burst: immediate return to reset values; the downstream side is assumed reset by the same resetn.
- Only one outstanding burst at a time; no write/read overlap.

Decomposition:
- Package cache_bus_pkg holds:
  - state enum
  - owner enum {OWN_I, OWN_D}
  - LINE_WORDS
  - line_t typedef (logic [255:0])
  - word-slice helper function
- One natural sub-module: line_buffer_8x32. Fields: 8-word register, load-line port, beat write port with index, beat read mux. It is used for both pack and unpack.
- Arbitration and the FSM stay in the top module.

Test Plan:
- I-only read, all bus handshakes tied 1, rdata = base+k for beat k, addr 0x1FC0_0024: bus_addr=0x1FC0_0020, i_gnt at cycle 10, i_rd_data word k = base+k, d_gnt never.
- D writeback then refill, d_wr_data words = 0xA0+k, bus_wready low every other cycle: 8 wdata beats in order, wlast only on the 8th, d_gnt pulse after bvalid, then the refill starts after re-arbitration.
- Simultaneous i_rd_req and d_rd_req from reset: icache was last_served, so D is served first, then I; both gnts are exactly 1 cycle; both rd_data are correct.
- Continuous I and D requests for 6 transactions: grants alternate D, I, D, I, D, I.
- Early bus_rlast on beat 5: bus_err=1 and sticky; i_gnt is still produced after beat 8.
- resetn pulsed low during beat 4 of a read: outputs go to 0 asynchronously and no gnt is issued; after release, a new request completes normally.
